// File: rtl/mult_sweep_checker.sv
// Exhaustive stimulus-and-scoring wrapper for a combinational candidate multiplier.
// Drives every {B,A} pair, compares P against the exact product and reports the results.
module mult_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   err_count,
  output logic               pass,
  output logic               first_err_valid,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  localparam int IW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // With no settle time every vector goes straight to the compare cycle.
  localparam state_t VEC_ENTRY = (SETTLE == 0) ? S_CHECK : S_SETTLE;
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_LAST = '1;

  state_t state;
  state_t state_next;

  logic [IW-1:0] idx;
  logic [3:0]    settle_cnt;
  logic [IW-1:0] exact;
  logic          mismatch;
  logic          last_vec;
  logic          settle_done;
  logic [IW:0]   err_next;

  assign A = idx[WIDTH-1:0];
  assign B = idx[IW-1:WIDTH];

  assign exact       = IW'(A) * IW'(B);
  assign mismatch    = (state == S_CHECK) && (P != exact);
  assign last_vec    = (idx == IDX_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign err_next    = err_count + (IW + 1)'(mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = VEC_ENTRY;
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (last_vec) begin
          state_next = S_DONE;
        end else begin
          state_next = VEC_ENTRY;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state == S_SETTLE) || (state == S_CHECK);
    done = (state == S_DONE);
  end

  // pass is resolved on the edge entering DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      settle_cnt      <= '0;
      err_count       <= '0;
      pass            <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx             <= '0;
            settle_cnt      <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_done) begin
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_a     <= A;
            first_err_b     <= B;
          end
          if (last_vec) begin
            pass <= (err_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Directed bench for mult_sweep_checker: three instances (SETTLE = 0, 1, 3) driven by
// behavioural candidate multipliers, checked against hand-computed sweep results.
module tb_mult_sweep_checker;

  logic       clk;
  logic       rst;
  int         cand_mode;
  int         compared;
  int         mismatched;

  logic       start_v [3];
  logic [1:0] a_v     [3];
  logic [1:0] b_v     [3];
  logic [3:0] p_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [4:0] err_v   [3];
  logic       pass_v  [3];
  logic       fev_v   [3];
  logic [1:0] fa_v    [3];
  logic [1:0] fb_v    [3];

  typedef struct {
    int which;
    int mode;
    int done_cycle;
    int err;
    int pass;
    int fev;
    int fa;
    int fb;
  } vec_t;

  vec_t vecs [7];

  // Candidates: 0 exact, 1 stuck at zero, 2 wrong only at 3*3, 3 stuck at all ones.
  function automatic logic [3:0] cand(input int mode, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] ex;
    ex = {2'b00, a} * {2'b00, b};
    case (mode)
      1:       return 4'd0;
      2:       return (a == 2'd3 && b == 2'd3) ? 4'd8 : ex;
      3:       return 4'hF;
      default: return ex;
    endcase
  endfunction

  function automatic int settle_of(input int which);
    return (which == 0) ? 0 : (which == 1) ? 1 : 3;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int S = (g == 0) ? 0 : (g == 1) ? 1 : 3;
      assign p_v[g] = cand(cand_mode, a_v[g], b_v[g]);
      mult_sweep_checker #(.WIDTH(2), .SETTLE(S)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start_v[g]),
        .A               (a_v[g]),
        .B               (b_v[g]),
        .P               (p_v[g]),
        .busy            (busy_v[g]),
        .done            (done_v[g]),
        .err_count       (err_v[g]),
        .pass            (pass_v[g]),
        .first_err_valid (fev_v[g]),
        .first_err_a     (fa_v[g]),
        .first_err_b     (fb_v[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulses start for one edge; returns #1 after that edge (cycle 1 of the sweep).
  task automatic applyStimulus(input int which);
    @(posedge clk);
    #1;
    start_v[which] = 1'b1;
    @(posedge clk);
    #1;
    start_v[which] = 1'b0;
  endtask

  task automatic run_sweep(input vec_t v);
    int         w;
    int         s;
    int         n;
    int         busy_cnt;
    int         ab_bad;
    int         done_at;
    int         exp_idx;
    logic [3:0] ab;
    w = v.which;
    s = settle_of(w);
    cand_mode = v.mode;
    applyStimulus(w);
    checkOutput("start_clears_err", int'(err_v[w]), 0);
    checkOutput("start_clears_fev", int'(fev_v[w]), 0);
    checkOutput("start_clears_pass", int'(pass_v[w]), 0);
    n = 1;
    busy_cnt = 0;
    ab_bad = 0;
    done_at = 0;
    while (done_at == 0 && n <= 200) begin
      if (busy_v[w]) busy_cnt++;
      exp_idx = (n - 1) / (s + 1);
      if (exp_idx > 15) exp_idx = 15;
      ab = {b_v[w], a_v[w]};
      if (int'(ab) != exp_idx) ab_bad++;
      if (done_v[w]) begin
        done_at = n;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    checkOutput("done_cycle", done_at, v.done_cycle);
    checkOutput("busy_cycles", busy_cnt, v.done_cycle - 1);
    checkOutput("ab_sequence_errors", ab_bad, 0);
    checkOutput("err_count", int'(err_v[w]), v.err);
    checkOutput("pass", int'(pass_v[w]), v.pass);
    checkOutput("first_err_valid", int'(fev_v[w]), v.fev);
    checkOutput("first_err_a", int'(fa_v[w]), v.fa);
    checkOutput("first_err_b", int'(fb_v[w]), v.fb);
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", int'(done_v[w]), 0);
    checkOutput("pass_held", int'(pass_v[w]), v.pass);
    checkOutput("err_held", int'(err_v[w]), v.err);
  endtask

  initial begin
    int done_cnt;
    int done_at;
    int busy_after;

    compared = 0;
    mismatched = 0;
    cand_mode = 0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

    //          which mode done err pass fev fa fb
    vecs[0] = '{1, 0, 33,  0, 1, 0, 0, 0};
    vecs[1] = '{1, 1, 33,  9, 0, 1, 1, 1};
    vecs[2] = '{1, 0, 33,  0, 1, 0, 0, 0};
    vecs[3] = '{1, 2, 33,  1, 0, 1, 3, 3};
    vecs[4] = '{1, 3, 33, 16, 0, 1, 0, 0};
    vecs[5] = '{0, 0, 17,  0, 1, 0, 0, 0};
    vecs[6] = '{2, 0, 65,  0, 1, 0, 0, 0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", int'({a_v[1], b_v[1], busy_v[1], done_v[1], err_v[1],
                                     pass_v[1], fev_v[1], fa_v[1], fb_v[1]}), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i]);
    end

    // Extra starts mid-sweep and during DONE must be ignored.
    cand_mode = 0;
    applyStimulus(1);
    done_cnt = 0;
    done_at = 0;
    busy_after = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done_v[1]) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (n > 33 && busy_v[1]) busy_after++;
      start_v[1] = (n == 5 || n == 20 || n == 33);
      @(posedge clk);
      #1;
    end
    start_v[1] = 1'b0;
    checkOutput("ignored_start_done_count", done_cnt, 1);
    checkOutput("ignored_start_done_cycle", done_at, 33);
    checkOutput("ignored_start_busy_after", busy_after, 0);
    checkOutput("ignored_start_err", int'(err_v[1]), 0);
    checkOutput("ignored_start_pass", int'(pass_v[1]), 1);

    // Reset part-way through a failing sweep.
    cand_mode = 3;
    applyStimulus(1);
    for (int n = 1; n < 10; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_err", int'(err_v[1]), 4);
    checkOutput("pre_reset_fev", int'(fev_v[1]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid_reset_outputs", int'({a_v[1], b_v[1], busy_v[1], done_v[1], err_v[1],
                                           pass_v[1], fev_v[1], fa_v[1], fb_v[1]}), 0);
    done_cnt = 0;
    busy_after = 0;
    for (int n = 0; n < 40; n++) begin
      if (done_v[1]) done_cnt++;
      if (busy_v[1]) busy_after++;
      @(posedge clk);
      #1;
    end
    checkOutput("post_reset_no_done", done_cnt, 0);
    checkOutput("post_reset_idle", busy_after, 0);
    run_sweep(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
